// File: rtl/rvfi_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_retire_fifo
// Purpose  : Retirement-trace buffer. Compacts up to NRET RVFI retirement
//            packets per cycle, stamps each with an instruction order, and
//            drains them one per cycle over a valid/ready port. Overflow is
//            either back-pressured (stall) or dropped and counted (drop).
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_retire_fifo #(
  parameter int XLEN      = 32,
  parameter int NRET      = 2,
  parameter int DEPTH     = 16,
  parameter int DROP_MODE = 0,
  parameter int PKT_W     = 4*XLEN + 39 + XLEN/4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRET-1:0]        ret_valid,
  input  logic [NRET*PKT_W-1:0]  ret_pkt,
  output logic                   ret_stall,
  input  logic                   order_load,
  input  logic [63:0]            order_wdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PKT_W-1:0]       out_pkt,
  output logic [63:0]            out_order,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);
  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  // Bit positions of trap/intr inside one lane packet
  localparam int TRAP_BIT = 2*XLEN + 32;
  localparam int INTR_BIT = 2*XLEN + 33;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [63:0]      order_cnt;
  logic [PKT_W-1:0] mem_pkt [DEPTH];
  logic [63:0]      mem_ord [DEPTH];

  logic [PW-1:0]    free;
  logic [PW-1:0]    n_valid;
  logic [PW-1:0]    n_acc;
  logic [PW-1:0]    n_drop;
  logic [PW-1:0]    lane_pos [NRET];
  logic [AW-1:0]    wr_idx   [NRET];
  logic [63:0]      stamp    [NRET];
  logic [63:0]      order_next;
  logic [NRET-1:0]  lane_wr;
  logic [16:0]      drop_sum;
  logic             pop;

  // Occupancy and head are derived from registered pointers only
  assign level     = wr_ptr - rd_ptr;
  assign free      = PW'(DEPTH) - level;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_pkt   = mem_pkt[rd_ptr[AW-1:0]];
  assign out_order = mem_ord[rd_ptr[AW-1:0]];

  generate
    if (DROP_MODE != 0) begin : g_drop
      // Take lanes in order while space lasts, drop the tail
      assign ret_stall = 1'b0;
      assign n_acc     = (n_valid < free) ? n_valid : free;
    end else begin : g_stall
      // Refuse the whole group when a full NRET group would not fit
      assign ret_stall = (free < PW'(NRET));
      assign n_acc     = ret_stall ? '0 : n_valid;
    end
  endgenerate

  // Compact valid lanes into consecutive slots and stamp their order
  always_comb begin
    logic [63:0]   run;
    logic [PW-1:0] cnt;
    run = order_load ? order_wdata : order_cnt;
    cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      stamp[i]    = run;
      lane_pos[i] = cnt;
      if (ret_valid[i]) begin
        cnt = cnt + PW'(1);
        // Traps/interrupts carry the next order and do not consume one
        if (!ret_pkt[i*PKT_W + TRAP_BIT] && !ret_pkt[i*PKT_W + INTR_BIT])
          run = run + 64'd1;
      end
    end
    n_valid    = cnt;
    order_next = run;
  end

  // Decide which lanes land in the buffer and how many are lost
  always_comb begin
    logic [PW-1:0] tmp;
    lane_wr = '0;
    for (int i = 0; i < NRET; i++) begin
      tmp        = wr_ptr + lane_pos[i];
      wr_idx[i]  = tmp[AW-1:0];
      lane_wr[i] = ret_valid[i] && (lane_pos[i] < n_acc) && !flush;
    end
    // Pushes discarded by a flush are not losses
    n_drop   = flush ? '0 : (n_valid - n_acc);
    drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  // Packet storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (lane_wr[i]) begin
        mem_pkt[wr_idx[i]] <= ret_pkt[i*PKT_W +: PKT_W];
        mem_ord[wr_idx[i]] <= stamp[i];
      end
    end
  end

  // Pointers, order counter and loss accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      order_cnt <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      order_cnt <= order_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + n_acc;
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvfi_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_retire_fifo
// Purpose  : Self-checking bench. Drives one stall-mode (DEPTH=16) and one
//            drop-mode (DEPTH=4) instance from the same stimulus and compares
//            both against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvfi_retire_fifo;
  localparam int XLEN     = 32;
  localparam int NRET     = 2;
  localparam int PKT_W    = 4*XLEN + 39 + XLEN/4;
  localparam int DA       = 16;
  localparam int DB       = 4;
  localparam int TRAP_BIT = 2*XLEN + 32;
  localparam int INTR_BIT = 2*XLEN + 33;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NRET-1:0]       ret_valid;
  logic [NRET*PKT_W-1:0] ret_pkt;
  logic                  order_load;
  logic [63:0]           order_wdata;
  logic                  flush;
  logic                  out_ready;

  logic ret_stall_a, out_valid_a, overflow_a;
  logic ret_stall_b, out_valid_b, overflow_b;
  logic [PKT_W-1:0] out_pkt_a, out_pkt_b;
  logic [63:0]      out_order_a, out_order_b;
  logic [4:0]       level_a;
  logic [2:0]       level_b;
  logic [15:0]      drop_cnt_a, drop_cnt_b;

  rvfi_retire_fifo #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DA), .DROP_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pkt(ret_pkt),
    .ret_stall(ret_stall_a), .order_load(order_load), .order_wdata(order_wdata),
    .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pkt(out_pkt_a), .out_order(out_order_a), .level(level_a),
    .overflow(overflow_a), .drop_cnt(drop_cnt_a));

  rvfi_retire_fifo #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DB), .DROP_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pkt(ret_pkt),
    .ret_stall(ret_stall_b), .order_load(order_load), .order_wdata(order_wdata),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pkt(out_pkt_b), .out_order(out_order_b), .level(level_b),
    .overflow(overflow_b), .drop_cnt(drop_cnt_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic [63:0]      ord;
  } ent_t;
  typedef ent_t entq_t [$];

  entq_t       qa, qb;
  int          dca, dcb;
  bit          ova, ovb;
  logic [63:0] m_order;
  logic [63:0] m_stamp [NRET];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    dca = 0; dcb = 0; ova = 0; ovb = 0;
    m_order = 64'd0;
  endtask

  task automatic fifo_step(ref entq_t q, input int dep, input bit drp, ref int dc, ref bit ov);
    int  free, n, acc, k;
    bit  stall;
    ent_t e;
    free  = dep - q.size();
    stall = !drp && (free < NRET);
    n = 0;
    for (int i = 0; i < NRET; i++) n += int'(ret_valid[i]);
    if (drp) acc = (n < free) ? n : free;
    else     acc = stall ? 0 : n;
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (flush) begin
      q.delete();
    end else begin
      k = 0;
      for (int i = 0; i < NRET; i++) begin
        if (ret_valid[i]) begin
          if (k < acc) begin
            e.pkt = ret_pkt[i*PKT_W +: PKT_W];
            e.ord = m_stamp[i];
            q.push_back(e);
          end
          k++;
        end
      end
      if (n > acc) begin
        ov = 1'b1;
        dc = (dc + n - acc > 65535) ? 65535 : dc + n - acc;
      end
    end
  endtask

  task automatic model_edge();
    logic [63:0] run;
    run = order_load ? order_wdata : m_order;
    for (int i = 0; i < NRET; i++) begin
      m_stamp[i] = run;
      if (ret_valid[i] && !ret_pkt[i*PKT_W + TRAP_BIT] && !ret_pkt[i*PKT_W + INTR_BIT])
        run += 64'd1;
    end
    m_order = run;
    fifo_step(qa, DA, 1'b0, dca, ova);
    fifo_step(qb, DB, 1'b1, dcb, ovb);
  endtask

  task automatic check_dut(input string n, ref entq_t q, input int dep, input bit drp,
                           input int dc, input bit ov, input logic vld, input logic stl,
                           input logic [63:0] lvl, input logic [PKT_W-1:0] pkt,
                           input logic [63:0] ord, input logic ovf, input logic [15:0] dcnt);
    check({n, "_out_valid"}, vld, q.size() > 0);
    check({n, "_level"}, lvl, q.size());
    check({n, "_ret_stall"}, stl, !drp && ((dep - q.size()) < NRET));
    check({n, "_overflow"}, ovf, ov);
    check({n, "_drop_cnt"}, dcnt, dc);
    if (q.size() > 0) begin
      check({n, "_out_pkt"}, pkt, q[0].pkt);
      check({n, "_out_order"}, ord, q[0].ord);
    end
  endtask

  task automatic check_all();
    check_dut("a", qa, DA, 1'b0, dca, ova, out_valid_a, ret_stall_a, 64'(level_a),
              out_pkt_a, out_order_a, overflow_a, drop_cnt_a);
    check_dut("b", qb, DB, 1'b1, dcb, ovb, out_valid_b, ret_stall_b, 64'(level_b),
              out_pkt_b, out_order_b, overflow_b, drop_cnt_b);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic [1:0] v, input logic [1:0] t, input logic [1:0] ir,
                        input logic ld, input logic [63:0] wd, input logic fl, input logic rdy);
    logic [PKT_W-1:0] p;
    for (int i = 0; i < NRET; i++) begin
      for (int b = 0; b < PKT_W; b++) p[b] = 1'($urandom_range(0, 1));
      p[TRAP_BIT] = t[i];
      p[INTR_BIT] = ir[i];
      ret_pkt[i*PKT_W +: PKT_W] = p;
    end
    ret_valid   = v;
    order_load  = ld;
    order_wdata = wd;
    flush       = fl;
    out_ready   = rdy;
  endtask

  // Inputs are set on the falling edge; model and checks follow the rising edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    set_in(2'b00, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b1);
    guard = 0;
    while ((level_a != 0 || level_b != 0) && guard < 40) begin
      step();
      guard++;
    end
    check("drain_a_empty", level_a, 0);
    check("drain_b_empty", level_b, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  t;
    logic        ld;
    logic [63:0] wd;
    logic        fl;
    int          lva, hda, lvb, hdb, dcb;
  } vec_t;
  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v, t, ir;
    // Out-of-order cycles with out_ready=1; expectations derived by hand
    tbl[0] = '{2'b11, 2'b00, 1'b0, 64'd0,   1'b0, 2, 0,   2, 0,   0};
    tbl[1] = '{2'b11, 2'b00, 1'b0, 64'd0,   1'b0, 3, 1,   3, 1,   0};
    tbl[2] = '{2'b11, 2'b00, 1'b0, 64'd0,   1'b0, 4, 2,   3, 2,   1};
    tbl[3] = '{2'b11, 2'b00, 1'b0, 64'd0,   1'b0, 5, 3,   3, 3,   2};
    tbl[4] = '{2'b11, 2'b01, 1'b1, 64'd5,   1'b0, 6, 4,   3, 4,   3};
    tbl[5] = '{2'b10, 2'b00, 1'b0, 64'd0,   1'b0, 6, 5,   3, 6,   3};
    tbl[6] = '{2'b11, 2'b00, 1'b1, 64'd100, 1'b0, 7, 6,   3, 5,   4};
    tbl[7] = '{2'b11, 2'b00, 1'b1, 64'd100, 1'b1, 0, -1,  0, -1,  4};
    tbl[8] = '{2'b01, 2'b00, 1'b0, 64'd0,   1'b0, 1, 102, 1, 102, 4};

    set_in(2'b00, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b1);
    model_reset();
    #2;
    check_all();
    check("reset_stall_a", ret_stall_a, 1'b0);
    check("reset_valid_a", out_valid_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      set_in(tbl[k].v, tbl[k].t, 2'b00, tbl[k].ld, tbl[k].wd, tbl[k].fl, 1'b1);
      step();
      check($sformatf("tbl%0d_level_a", k), level_a, tbl[k].lva);
      check($sformatf("tbl%0d_level_b", k), level_b, tbl[k].lvb);
      check($sformatf("tbl%0d_drop_b", k), drop_cnt_b, tbl[k].dcb);
      if (tbl[k].hda >= 0) check($sformatf("tbl%0d_order_a", k), out_order_a, tbl[k].hda);
      if (tbl[k].hdb >= 0) check($sformatf("tbl%0d_order_b", k), out_order_b, tbl[k].hdb);
    end
    check("tbl_overflow_b", overflow_b, 1'b1);
    check("tbl_overflow_a", overflow_a, 1'b0);
    drain();

    // Stall mode back-pressure with a producer that obeys ret_stall
    set_in(2'b01, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 20; c++) begin
      set_in(ret_stall_a ? 2'b00 : 2'b11, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b0);
      step();
    end
    check("stall_level_a", level_a, 15);
    check("stall_flag_a", ret_stall_a, 1'b1);
    check("stall_nodrop_a", drop_cnt_a, 16'd0);
    check("stall_full_b", level_b, 4);
    drain();

    // Asynchronous reset with level 7
    set_in(2'b01, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3; c++) begin
      set_in(2'b11, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b0);
      step();
    end
    check("prereset_level_a", level_a, 7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid_a", out_valid_a, 1'b0);
    check("rst_level_a", level_a, 0);
    check("rst_valid_b", out_valid_b, 1'b0);
    check("rst_overflow_b", overflow_b, 1'b0);
    check("rst_drop_b", drop_cnt_b, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(2'b01, 2'b00, 2'b00, 1'b0, 64'd0, 1'b0, 1'b0);
    step();
    check("post_rst_order_a", out_order_a, 64'd0);
    check("post_rst_order_b", out_order_b, 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      v  = 2'($urandom) & {2{~ret_stall_a}};
      t  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      ir = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)};
      set_in(v, t, ir, ($urandom_range(0, 49) == 0), {32'($urandom), 32'($urandom)},
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
